// File: rtl/bus_pkg.sv
// Definitions shared by the serial bus master and slave: state encoding,
// slave ID width and the fixed framing bit values.
package bus_pkg;

    localparam int unsigned SID_WIDTH = 3;
    localparam logic        START_BIT = 1'b0;
    localparam logic        SYNC_BIT  = 1'b1;

    typedef enum logic [3:0] {
        StIdle        = 4'd0,
        StReqBus      = 4'd1,
        StStart0      = 4'd2,
        StStart1      = 4'd3,
        StTxSid       = 4'd4,
        StTxAddr      = 4'd5,
        StWaitAddrAck = 4'd6,
        StAddrAck2    = 4'd7,
        StTxSync      = 4'd8,
        StTxData      = 4'd9,
        StWaitWrAck   = 4'd10,
        StWrAck2      = 4'd11,
        StWaitRdStart = 4'd12,
        StRxData      = 4'd13,
        StDone        = 4'd14,
        StError       = 4'd15
    } bus_state_e;

endpackage

// File: rtl/serial_shift_tx.sv
// MSB-first transmit shifter with a remaining-bit counter. Data is loaded
// left-aligned; last flags the bit currently presented on tx_bit.
module serial_shift_tx #(
    parameter int unsigned Width = 15,
    localparam int unsigned LenWidth = $clog2(Width + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic                shift,
    input  logic [Width-1:0]    load_data,
    input  logic [LenWidth-1:0] load_len,
    output logic                tx_bit,
    output logic                last
);

    logic [Width-1:0]    sr_q;
    logic [LenWidth-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= load_data;
            cnt_q <= load_len;
        end else if (shift && (cnt_q != '0)) begin
            sr_q  <= {sr_q[Width-2:0], 1'b0};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tx_bit = sr_q[Width-1];
    assign last   = (cnt_q == LenWidth'(1));

endmodule

// File: rtl/bus_master.sv
// Initiator end of the single-wire serial bus: arbitration, start/SID/address
// framing, address ack, then write data with ack or read data reception.
module bus_master
    import bus_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 15,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ACK_TIMEOUT   = 15,
    parameter int unsigned DATA_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    input  logic                     cmd_wr,
    input  logic [SID_WIDTH-1:0]     cmd_sid,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     arb_req,
    input  logic                     arb_grant,
    output logic                     bus_util,
    output logic                     rd_wrt,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic [3:0]               state_out,
    inout  wire                      data_bus_serial
);

    localparam int unsigned MaxTimeout = (ACK_TIMEOUT > DATA_TIMEOUT) ? ACK_TIMEOUT : DATA_TIMEOUT;
    localparam int unsigned CntWidth   = $clog2(MaxTimeout + 1);
    localparam int unsigned TxWidth0   = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int unsigned TxWidth    = (TxWidth0 > SID_WIDTH) ? TxWidth0 : SID_WIDTH;
    localparam int unsigned TxLenWidth = $clog2(TxWidth + 1);

    bus_state_e               state_q;
    logic                     wr_q;
    logic [SID_WIDTH-1:0]     sid_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [CntWidth-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0]    rx_q;
    logic [DATA_WIDTH-1:0]    rx_next;

    logic                     tx_load;
    logic                     tx_shift;
    logic [TxWidth-1:0]       tx_data;
    logic [TxLenWidth-1:0]    tx_len;
    logic                     tx_bit;
    logic                     tx_last;

    logic                     line_oe;
    logic                     line_do;
    logic                     line_in;

    serial_shift_tx #(
        .Width (TxWidth)
    ) u_tx (
        .clk       (clk),
        .rstn      (rstn),
        .load      (tx_load),
        .shift     (tx_shift),
        .load_data (tx_data),
        .load_len  (tx_len),
        .tx_bit    (tx_bit),
        .last      (tx_last)
    );

    // Each field is loaded on the edge entering its phase so its MSB is on
    // the line for the whole first cycle of that phase.
    always_comb begin
        tx_load = 1'b0;
        tx_data = '0;
        tx_len  = '0;
        case (state_q)
            StStart1: begin
                tx_load = 1'b1;
                tx_data = TxWidth'(sid_q) << (TxWidth - SID_WIDTH);
                tx_len  = TxLenWidth'(SID_WIDTH);
            end
            StTxSid: begin
                tx_load = tx_last;
                tx_data = TxWidth'(addr_q) << (TxWidth - ADDRESS_WIDTH);
                tx_len  = TxLenWidth'(ADDRESS_WIDTH);
            end
            StTxSync: begin
                tx_load = 1'b1;
                tx_data = TxWidth'(wdata_q) << (TxWidth - DATA_WIDTH);
                tx_len  = TxLenWidth'(DATA_WIDTH);
            end
            default: ;
        endcase
    end

    assign tx_shift = (state_q == StTxSid) || (state_q == StTxAddr) || (state_q == StTxData);

    always_comb begin
        line_oe = 1'b0;
        line_do = START_BIT;
        case (state_q)
            StStart0, StStart1: line_oe = 1'b1;
            StTxSid, StTxAddr, StTxData: begin
                line_oe = 1'b1;
                line_do = tx_bit;
            end
            StTxSync: begin
                line_oe = 1'b1;
                line_do = SYNC_BIT;
            end
            default: ;
        endcase
    end

    assign data_bus_serial = line_oe ? line_do : 1'bz;
    assign line_in         = data_bus_serial;
    assign rx_next         = {rx_q[DATA_WIDTH-2:0], line_in};
    assign busy            = (state_q != StIdle);
    assign state_out       = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            wr_q     <= 1'b0;
            sid_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rx_q     <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            arb_req  <= 1'b0;
            bus_util <= 1'b0;
            rd_wrt   <= 1'b0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            // Any state that does not count leaves the counter cleared, so
            // every wait state starts from zero on entry.
            cnt_q <= '0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        wr_q    <= cmd_wr;
                        sid_q   <= cmd_sid;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        arb_req <= 1'b1;
                        state_q <= StReqBus;
                    end
                end
                StReqBus: begin
                    if (arb_grant) begin
                        bus_util <= 1'b1;
                        rd_wrt   <= wr_q;
                        state_q  <= StStart0;
                    end
                end
                StStart0: state_q <= StStart1;
                StStart1: state_q <= StTxSid;
                StTxSid: begin
                    if (tx_last) state_q <= StTxAddr;
                end
                StTxAddr: begin
                    if (tx_last) state_q <= StWaitAddrAck;
                end
                StWaitAddrAck: begin
                    if (!line_in) begin
                        state_q <= StAddrAck2;
                    end else if (cnt_q >= CntWidth'(ACK_TIMEOUT)) begin
                        err     <= 1'b1;
                        state_q <= StError;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAddrAck2: begin
                    if (line_in) begin
                        err     <= 1'b1;
                        state_q <= StError;
                    end else begin
                        state_q <= wr_q ? StTxSync : StWaitRdStart;
                    end
                end
                StTxSync: state_q <= StTxData;
                StTxData: begin
                    if (tx_last) state_q <= StWaitWrAck;
                end
                StWaitWrAck: begin
                    if (!line_in) begin
                        state_q <= StWrAck2;
                    end else if (cnt_q >= CntWidth'(DATA_TIMEOUT)) begin
                        err     <= 1'b1;
                        state_q <= StError;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWrAck2: begin
                    if (line_in) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        err     <= 1'b1;
                        state_q <= StError;
                    end
                end
                StWaitRdStart: begin
                    if (!line_in) begin
                        state_q <= StRxData;
                    end else if (cnt_q >= CntWidth'(DATA_TIMEOUT)) begin
                        err     <= 1'b1;
                        state_q <= StError;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRxData: begin
                    rx_q  <= rx_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntWidth'(DATA_WIDTH - 1)) begin
                        rdata   <= rx_next;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone, StError: begin
                    bus_util <= 1'b0;
                    arb_req  <= 1'b0;
                    rd_wrt   <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: cycle-exact write, read, timeout, bad ack,
// delayed grant and mid-transaction reset, with a scripted slave on the line.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [2:0]  cmd_sid = '0;
    logic [14:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        arb_grant = 1'b0;
    wire         arb_req;
    wire         bus_util;
    wire         rd_wrt;
    wire  [7:0]  rdata;
    wire         done;
    wire         err;
    wire         busy;
    wire  [3:0]  state_out;
    wire         data_bus_serial;

    logic        s_oe = 1'b0;
    logic        s_do = 1'b1;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] wr_line;
    logic [19:0] rd_line;
    logic [7:0]  rd_word;

    assign data_bus_serial = s_oe ? s_do : 1'bz;
    pullup (data_bus_serial);

    always #5 clk = ~clk;

    bus_master dut (
        .clk             (clk),
        .rstn            (rstn),
        .cmd_valid       (cmd_valid),
        .cmd_wr          (cmd_wr),
        .cmd_sid         (cmd_sid),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .arb_req         (arb_req),
        .arb_grant       (arb_grant),
        .bus_util        (bus_util),
        .rd_wrt          (rd_wrt),
        .rdata           (rdata),
        .done            (done),
        .err             (err),
        .busy            (busy),
        .state_out       (state_out),
        .data_bus_serial (data_bus_serial)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write timeline from the START0 cycle: 20 framing bits, release, 2 ack,
    // sync, 8 data bits, one idle cycle then the slave's 0/1 ack.
    function automatic logic [3:0] wr_state(input int i);
        if (i < 1)  return 4'd2;
        if (i < 2)  return 4'd3;
        if (i < 5)  return 4'd4;
        if (i < 20) return 4'd5;
        if (i < 22) return 4'd6;
        if (i < 23) return 4'd7;
        if (i < 24) return 4'd8;
        if (i < 32) return 4'd9;
        if (i < 34) return 4'd10;
        if (i < 35) return 4'd11;
        return 4'd14;
    endfunction

    function automatic logic [3:0] rd_state(input int i);
        if (i < 1)  return 4'd2;
        if (i < 2)  return 4'd3;
        if (i < 5)  return 4'd4;
        if (i < 20) return 4'd5;
        if (i < 22) return 4'd6;
        if (i < 23) return 4'd7;
        if (i < 25) return 4'd12;
        if (i < 33) return 4'd13;
        return 4'd14;
    endfunction

    // Leaves the bench at the START0 cycle (grant must already be high).
    task automatic issue(input logic wr, input logic [2:0] sid, input logic [14:0] addr,
                         input logic [7:0] wd);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_sid   = sid;
        cmd_addr  = addr;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_wr    = ~wr;
        cmd_sid   = ~sid;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;
        #1;
        chk("issue_state", state_out, 32'd1);
        chk("issue_arb_req", arb_req, 32'd1);
        tick();
    endtask

    task automatic write_txn(input string tag);
        issue(1'b1, 3'b010, 15'h1234, 8'hA5);
        for (int i = 0; i < 36; i++) begin
            s_oe      = (i == 21) || (i == 22) || (i == 33) || (i == 34);
            s_do      = (i == 34);
            arb_grant = (i < 10);
            #1;
            if (i < 32) chk({tag, "_line"}, data_bus_serial, 32'(wr_line[31-i]));
            chk({tag, "_state"}, state_out, 32'(wr_state(i)));
            chk({tag, "_done"}, done, 32'(i == 35));
            if (i == 0) begin
                chk({tag, "_bus_util"}, bus_util, 32'd1);
                chk({tag, "_rd_wrt"}, rd_wrt, 32'd1);
            end
            if (i == 35) chk({tag, "_util_in_done"}, bus_util, 32'd1);
            tick();
        end
        s_oe      = 1'b0;
        arb_grant = 1'b1;
        #1;
        chk({tag, "_end_state"}, state_out, 32'd0);
        chk({tag, "_end_done"}, done, 32'd0);
        chk({tag, "_end_util"}, bus_util, 32'd0);
        chk({tag, "_end_req"}, arb_req, 32'd0);
        chk({tag, "_end_busy"}, busy, 32'd0);
        chk({tag, "_end_rdata"}, rdata, 32'h00);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        wr_line = {2'b00, 3'b010, 15'h1234, 1'b1, 2'b00, 1'b1, 8'hA5};
        rd_line = {2'b00, 3'b101, 15'h0007};
        rd_word = 8'h3C;

        // Reset state
        #2;
        chk("rst_state", state_out, 32'd0);
        chk("rst_outs", {arb_req, bus_util, rd_wrt, done, err, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'h00);
        chk("rst_line", data_bus_serial, 32'd1);
        #10;
        rstn      = 1'b1;
        arb_grant = 1'b1;
        tick();
        chk("idle_state", state_out, 32'd0);

        write_txn("wr1");

        // Read with one idle cycle before the start bit
        issue(1'b0, 3'b101, 15'h0007, 8'h00);
        for (int i = 0; i < 34; i++) begin
            s_oe = (i == 21) || (i == 22) || ((i >= 24) && (i <= 32));
            if ((i >= 25) && (i <= 32)) s_do = rd_word[32-i];
            else s_do = 1'b0;
            #1;
            if (i < 20) chk("rd_line", data_bus_serial, 32'(rd_line[19-i]));
            if (i == 20) chk("rd_release", data_bus_serial, 32'd1);
            chk("rd_state", state_out, 32'(rd_state(i)));
            if (i == 0) chk("rd_rd_wrt", rd_wrt, 32'd0);
            if (i == 32) chk("rd_rdata_early", rdata, 32'h00);
            if (i == 33) begin
                chk("rd_rdata", rdata, 32'h3C);
                chk("rd_done", done, 32'd1);
                chk("rd_util", bus_util, 32'd1);
            end
            tick();
        end
        s_oe = 1'b0;
        #1;
        chk("rd_after_util", bus_util, 32'd0);
        chk("rd_after_done", done, 32'd0);
        chk("rd_after_rdata", rdata, 32'h3C);
        tick();

        // No slave: ack timeout
        issue(1'b1, 3'b110, 15'h4001, 8'h5A);
        for (int i = 0; i < 38; i++) begin
            #1;
            if (i == 35) begin
                chk("to_wait_state", state_out, 32'd6);
                chk("to_no_early_err", err, 32'd0);
            end
            if (i == 36) begin
                chk("to_err_state", state_out, 32'd15);
                chk("to_err", err, 32'd1);
                chk("to_no_done", done, 32'd0);
                chk("to_line", data_bus_serial, 32'd1);
            end
            if (i == 37) begin
                chk("to_idle", state_out, 32'd0);
                chk("to_err_pulse", err, 32'd0);
                chk("to_util", bus_util, 32'd0);
                chk("to_rdata_kept", rdata, 32'h3C);
            end
            tick();
        end

        // Single low ack cycle
        issue(1'b0, 3'b001, 15'h0100, 8'h00);
        for (int i = 0; i < 25; i++) begin
            s_oe = (i == 21);
            s_do = 1'b0;
            #1;
            if (i == 21) chk("ack1_wait", state_out, 32'd6);
            if (i == 22) chk("ack1_ack2", state_out, 32'd7);
            if (i == 23) begin
                chk("ack1_err_state", state_out, 32'd15);
                chk("ack1_err", err, 32'd1);
                chk("ack1_no_done", done, 32'd0);
            end
            if (i == 24) begin
                chk("ack1_idle", state_out, 32'd0);
                chk("ack1_err_pulse", err, 32'd0);
            end
            tick();
        end
        s_oe = 1'b0;

        // Grant held off; a second command while busy is dropped
        arb_grant = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_sid   = 3'b010;
        cmd_addr  = 15'h1234;
        cmd_wdata = 8'hA5;
        tick();
        cmd_wr = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("gnt_req", arb_req, 32'd1);
            chk("gnt_busy", busy, 32'd1);
            chk("gnt_state", state_out, 32'd1);
            chk("gnt_line", data_bus_serial, 32'd1);
            chk("gnt_util", bus_util, 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        arb_grant = 1'b1;
        tick();
        for (int i = 0; i <= 8; i++) begin
            #1;
            chk("gnt_tx_line", data_bus_serial, 32'(wr_line[31-i]));
            chk("gnt_tx_state", state_out, 32'(wr_state(i)));
            if (i < 8) tick();
        end
        chk("gnt_rd_wrt", rd_wrt, 32'd1);

        // Asynchronous reset in the middle of the address phase
        rstn = 1'b0;
        #1;
        chk("mrst_line", data_bus_serial, 32'd1);
        chk("mrst_util", bus_util, 32'd0);
        chk("mrst_state", state_out, 32'd0);
        chk("mrst_req", arb_req, 32'd0);
        chk("mrst_busy", busy, 32'd0);
        chk("mrst_rdata", rdata, 32'h00);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();

        write_txn("wr2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
